elastic_pipereg: RTL and testbench
==================================

ELASTIC_PIPEREG -- requirements
Module: elastic_pipereg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload width in bits (1..512).
REQ-002 SHALL have parameter SKID_EN, default 1: 1 = two-entry skid mode, 0 = single-entry mode.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush, same effect as reset except stall_cnt.
REQ-006 SHALL have port in_valid  input  1  upstream payload valid.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  block accepts a payload this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).
REQ-013 SHALL have port stall_cnt  output  32  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 SHALL define in-fire = in_valid & in_ready and out-fire = out_valid & out_ready, both evaluated in the same cycle.
REQ-015 SHALL, in SKID_EN=1, hold registers main (data+valid) and skid (data+valid); out_valid/out_data SHALL come directly from main, no combinational path from in_* to out_*.
REQ-016 SHALL, in SKID_EN=1, drive in_ready = ~skid_valid, a registered signal with no dependence on out_ready.
REQ-017 SHALL, in SKID_EN=1, implement states EMPTY (occ 0), ONE (main only, occ 1), TWO (main+skid, occ 2).
REQ-018 EMPTY: in-fire -> ONE, main <= in_data; otherwise stay EMPTY.
REQ-019 ONE: in-fire & out-fire -> ONE, main <= in_data; in-fire only -> TWO, skid <= in_data; out-fire only -> EMPTY; neither -> ONE, main unchanged.
REQ-020 TWO: out-fire -> ONE, main <= skid; no out-fire -> TWO, both unchanged; in-fire impossible (in_ready=0).
REQ-021 SHALL, in SKID_EN=0, hold only main; in_ready = ~main_valid | out_ready (combinational); occupancy SHALL never exceed 1.
REQ-022 SHALL deliver payloads in acceptance order, none dropped or duplicated, latency 1 cycle from in-fire to out_valid when empty.
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on flush=1, next cycle clear main/skid valid and data to 0, occupancy 0; any in-fire in the flush cycle SHALL be discarded; flush overrides all transitions.
REQ-025 SHALL increment stall_cnt by 1 each cycle with out_valid=1 & out_ready=0, saturating at 32'hFFFF_FFFF (no wrap); flush SHALL NOT clear it.
REQ-026 SHALL drive occupancy = main_valid + skid_valid, registered.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set main/skid valid and data to 0, stall_cnt 0, occupancy 0; reset overrides flush and handshake.
REQ-028 SHALL present after reset: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-029 SHALL, on reset asserted mid-transfer (state TWO), discard both entries; first post-reset in-fire SHALL appear as the next output.

Verification
REQ-030 Streaming: SKID_EN=1, in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, occupancy stays 1, stall_cnt 0.
REQ-031 Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; out_ready=1 two cycles -> 0xA then 0xB, stall_cnt=cycles stalled.
REQ-032 Flush: state TWO holding 0x5,0x6, flush=1 with in_valid=1 data 0x7 -> next cycle out_valid=0, occupancy 0, 0x7 never appears, stall_cnt unchanged.
REQ-033 Saturation: preload/force long stall (or stall_cnt near 32'hFFFF_FFFE) -> reaches 32'hFFFF_FFFF and holds.
REQ-034 SKID_EN=0: out_valid=1, out_ready=1, in_valid=1 data 0x9 -> in_ready=1 same cycle, out_data=0x9 next cycle, occupancy never 2.
REQ-035 Random: random in_valid/out_ready, WIDTH=8 and 64, both modes -> scoreboard ordered, lossless, no duplicates.

Source files
------------

// File: rtl/elastic_pipereg.sv
// Elastic pipeline register: valid/ready stage with an optional skid entry so
// in_ready can be fully registered, plus a saturating downstream-stall counter.
//
// state   | meaning
// EMPTY   | nothing held, occupancy 0
// ONE     | main entry valid, occupancy 1
// TWO     | main and skid entries valid, occupancy 2 (SKID_EN=1 only)
module elastic_pipereg #(
    parameter int WIDTH   = 64,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [31:0]      stall_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic [31:0]      r_stall_cnt;
    logic             w_main_valid;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_main_valid = (r_state != S_EMPTY);

    // Skid mode decouples in_ready from out_ready; single-entry mode trades that
    // for one register by letting a draining entry admit the next payload.
    generate
        if (SKID_EN != 0) begin : g_skid
            assign w_in_ready = (r_state != S_TWO);
        end else begin : g_single
            assign w_in_ready = (r_state == S_EMPTY) | out_ready;
        end
    endgenerate

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_main_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = in_data;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data;
                end else if (w_in_fire) begin
                    if (SKID_EN != 0) begin
                        w_state_nxt = S_TWO;
                        w_skid_nxt  = in_data;
                    end
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = r_skid_data;
                    w_skid_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_main_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush) begin
                r_state     <= S_EMPTY;
                r_main_data <= '0;
                r_skid_data <= '0;
            end else begin
                r_state     <= w_state_nxt;
                r_main_data <= w_main_nxt;
                r_skid_data <= w_skid_nxt;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_elastic_pipereg.sv
// Bench for elastic_pipereg: four instances (WIDTH 64/8, skid on/off) share
// stimulus; a forked scoreboard tracks every accepted payload per instance.
module tb_elastic_pipereg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic [3:0]        ir_w;
    logic [3:0]        ov_w;
    logic [3:0][63:0]  od_w;
    logic [3:0][1:0]   occ_w;
    logic [3:0][31:0]  st_w;

    int n_checks = 0;
    int n_fail   = 0;
    bit sat_mode = 1'b0;

    logic [63:0] sb_q [4][$];
    logic [31:0] m_stall [4];
    logic        prev_hold [4];
    logic [63:0] prev_data [4];
    int          n_pop [4];

    always #5 clk = ~clk;

    // k: 0 = W64 skid, 1 = W8 skid, 2 = W64 single, 3 = W8 single
    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int W = (k % 2 == 0) ? 64 : 8;
        localparam int S = (k < 2) ? 1 : 0;
        logic [W-1:0] w_od;
        elastic_pipereg #(.WIDTH(W), .SKID_EN(S)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_data   (in_data[W-1:0]),
            .in_ready  (ir_w[k]),
            .out_valid (ov_w[k]),
            .out_data  (w_od),
            .out_ready (out_ready),
            .occupancy (occ_w[k]),
            .stall_cnt (st_w[k])
        );
        assign od_w[k] = 64'(w_od);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [63:0] mask;
        logic [63:0] exp_d;
        logic        exp_ir;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                mask = (k % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
                if (reset) begin
                    sb_q[k].delete();
                    m_stall[k]   = '0;
                    prev_hold[k] = 1'b0;
                    continue;
                end
                n_checks++;
                if (occ_w[k] !== 2'(sb_q[k].size())) begin
                    n_fail++;
                    $display("FAIL sb_occ[%0d]: got %0d expected %0d", k, occ_w[k], sb_q[k].size());
                end
                n_checks++;
                if (ov_w[k] !== (sb_q[k].size() != 0)) begin
                    n_fail++;
                    $display("FAIL sb_valid[%0d]: got %b expected %b", k, ov_w[k], sb_q[k].size() != 0);
                end
                exp_ir = (k < 2) ? (sb_q[k].size() < 2) : ((sb_q[k].size() == 0) || out_ready);
                n_checks++;
                if (ir_w[k] !== exp_ir) begin
                    n_fail++;
                    $display("FAIL sb_in_ready[%0d]: got %b expected %b", k, ir_w[k], exp_ir);
                end
                if (!(sat_mode && k == 0)) begin
                    n_checks++;
                    if (st_w[k] !== m_stall[k]) begin
                        n_fail++;
                        $display("FAIL sb_stall[%0d]: got %0d expected %0d", k, st_w[k], m_stall[k]);
                    end
                end
                if (prev_hold[k]) begin
                    n_checks++;
                    if (od_w[k] !== prev_data[k]) begin
                        n_fail++;
                        $display("FAIL sb_hold[%0d]: got %h expected %h", k, od_w[k], prev_data[k]);
                    end
                end
                if (ov_w[k] && out_ready) begin
                    n_checks++;
                    if (sb_q[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_extra[%0d]: got %h expected none", k, od_w[k]);
                    end else begin
                        exp_d = sb_q[k].pop_front();
                        n_pop[k]++;
                        if (od_w[k] !== exp_d) begin
                            n_fail++;
                            $display("FAIL sb_data[%0d]: got %h expected %h", k, od_w[k], exp_d);
                        end
                    end
                end
                if (flush) sb_q[k].delete();
                else if (in_valid && ir_w[k]) sb_q[k].push_back(in_data & mask);
                if (ov_w[k] && !out_ready && (m_stall[k] != 32'hFFFF_FFFF)) m_stall[k]++;
                prev_hold[k] = ov_w[k] && !out_ready && !flush;
                prev_data[k] = od_w[k];
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ov_w[k] !== 1'b0 || od_w[k] !== 64'd0 || ir_w[k] !== 1'b1 ||
                occ_w[k] !== 2'd0 || st_w[k] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got v=%b d=%h rdy=%b occ=%0d st=%0d expected v=0 d=0 rdy=1 occ=0 st=0",
                         k, ov_w[k], od_w[k], ir_w[k], occ_w[k], st_w[k]);
            end
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            tick();
            n_checks++;
            if (ov_w[0] !== 1'b1 || od_w[0] !== 64'(i) || occ_w[0] !== 2'd1 || st_w[0] !== 32'd0) begin
                n_fail++;
                $display("FAIL stream: got v=%b d=%h occ=%0d st=%0d expected v=1 d=%h occ=1 st=0",
                         ov_w[0], od_w[0], occ_w[0], st_w[0], 64'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (ov_w[0] !== 1'b0 || occ_w[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_drain: got v=%b occ=%0d expected v=0 occ=0", ov_w[0], occ_w[0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        n_checks++;
        if (occ_w[0] !== 2'd2 || ir_w[0] !== 1'b0 || od_w[0] !== 64'hA || st_w[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d rdy=%b d=%h st=%0d expected occ=2 rdy=0 d=a st=1",
                     occ_w[0], ir_w[0], od_w[0], st_w[0]);
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (od_w[0] !== 64'hA || st_w[0] !== 32'd2 || occ_w[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold: got d=%h st=%0d occ=%0d expected d=a st=2 occ=2", od_w[0], st_w[0], occ_w[0]);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (od_w[0] !== 64'hB || occ_w[0] !== 2'd1 || st_w[0] !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_second: got d=%h occ=%0d st=%0d expected d=b occ=1 st=2", od_w[0], occ_w[0], st_w[0]);
        end
        tick();
        n_checks++;
        if (ov_w[0] !== 1'b0 || occ_w[0] !== 2'd0 || st_w[0] !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b occ=%0d st=%0d expected v=0 occ=0 st=2", ov_w[0], occ_w[0], st_w[0]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h5;
        tick();
        in_data = 64'h6;
        tick();
        n_checks++;
        if (occ_w[0] !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_fill: got occ=%0d expected 2", occ_w[0]);
        end
        flush = 1'b1; in_data = 64'h7; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (ov_w[0] !== 1'b0 || occ_w[0] !== 2'd0 || od_w[0] !== 64'd0 || ir_w[0] !== 1'b1 || st_w[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL flush: got v=%b occ=%0d d=%h rdy=%b st=%0d expected v=0 occ=0 d=0 rdy=1 st=1",
                     ov_w[0], occ_w[0], od_w[0], ir_w[0], st_w[0]);
        end
        tick(); tick(); tick();
        n_checks++;
        if (ov_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ghost: got v=%b d=%h expected v=0", ov_w[0], od_w[0]);
        end
        in_valid = 1'b1; in_data = 64'h8; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (ov_w[0] !== 1'b1 || od_w[0] !== 64'h8) begin
            n_fail++;
            $display("FAIL flush_next: got v=%b d=%h expected v=1 d=8", ov_w[0], od_w[0]);
        end
        tick();
    endtask

    task automatic test_single_entry();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h8;
        tick();
        in_data = 64'h9;
        #1;
        n_checks++;
        if (ir_w[2] !== 1'b1 || ov_w[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pass: got rdy=%b v=%b expected rdy=1 v=1", ir_w[2], ov_w[2]);
        end
        tick();
        n_checks++;
        if (od_w[2] !== 64'h9 || occ_w[2] !== 2'd1) begin
            n_fail++;
            $display("FAIL single_data: got d=%h occ=%0d expected d=9 occ=1", od_w[2], occ_w[2]);
        end
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (ir_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_block: got rdy=%b expected 0", ir_w[2]);
        end
        tick();
        n_checks++;
        if (occ_w[2] !== 2'd1 || od_w[2] !== 64'h9) begin
            n_fail++;
            $display("FAIL single_occ: got occ=%0d d=%h expected occ=1 d=9", occ_w[2], od_w[2]);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
        tick();
        in_data = 64'h12;
        tick();
        reset = 1'b1; in_data = 64'h13;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (ov_w[0] !== 1'b0 || occ_w[0] !== 2'd0 || st_w[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b occ=%0d st=%0d expected v=0 occ=0 st=0", ov_w[0], occ_w[0], st_w[0]);
        end
        in_valid = 1'b1; in_data = 64'h14; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (ov_w[0] !== 1'b1 || od_w[0] !== 64'h14) begin
            n_fail++;
            $display("FAIL mid_reset_next: got v=%b d=%h expected v=1 d=14", ov_w[0], od_w[0]);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4; k++) n_pop[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 199) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (sb_q[k].size() != 0 || ov_w[k] !== 1'b0 || n_pop[k] < 200) begin
                n_fail++;
                $display("FAIL random_drain[%0d]: got left=%0d v=%b popped=%0d expected left=0 v=0 popped>=200",
                         k, sb_q[k].size(), ov_w[k], n_pop[k]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        sat_mode = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
        tick();
        in_valid = 1'b0;
        force g_dut[0].u_dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release g_dut[0].u_dut.r_stall_cnt;
        tick();
        n_checks++;
        if (st_w[0] !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL sat_step: got %h expected fffffffe", st_w[0]);
        end
        tick();
        n_checks++;
        if (st_w[0] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_top: got %h expected ffffffff", st_w[0]);
        end
        tick(); tick();
        n_checks++;
        if (st_w[0] !== 32'hFFFF_FFFF || od_w[0] !== 64'h55) begin
            n_fail++;
            $display("FAIL sat_hold: got st=%h d=%h expected st=ffffffff d=55", st_w[0], od_w[0]);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_stall[k] = '0; prev_hold[k] = 1'b0; prev_data[k] = '0; n_pop[k] = 0;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_single_entry();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
